fetch_line_unpacker: RTL

//  Downstream of the bus-fetch FSM (INITIAL/WAIT_RESP/GOT_RESP). Issues line-read requests to it,

---
 rtl/fetch_line_unpacker_if.sv | 29 ++
 rtl/fetch_line_unpacker.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_line_unpacker_if.sv
// Handshake bundle between the line unpacker, the bus-fetch FSM and decode.
// The master side drives the requests and beats; the slave side is the unpacker.
interface fetch_line_unpacker_if #(
    parameter int ADDR_WIDTH     = 64,
    parameter int BUS_DATA_WIDTH = 64
);
    logic                      start_valid;
    logic [ADDR_WIDTH-1:0]     start_pc;
    logic                      line_req_valid;
    logic [ADDR_WIDTH-1:0]     line_req_addr;
    logic                      line_req_ack;
    logic                      beat_valid;
    logic [BUS_DATA_WIDTH-1:0] beat_data;
    logic                      inst_valid;
    logic [31:0]               inst;
    logic [ADDR_WIDTH-1:0]     inst_pc;
    logic                      inst_ready;
    logic                      busy;

    modport master (
        output start_valid, start_pc, line_req_ack, beat_valid, beat_data, inst_ready,
        input  line_req_valid, line_req_addr, inst_valid, inst, inst_pc, busy
    );

    modport slave (
        input  start_valid, start_pc, line_req_ack, beat_valid, beat_data, inst_ready,
        output line_req_valid, line_req_addr, inst_valid, inst, inst_pc, busy
    );
endinterface

// File: rtl/fetch_line_unpacker.sv
// Requests cache-line reads, buffers the returned beats and streams 32-bit
// instructions with their PC to decode; redirects abandon and drain any line in flight.
module fetch_line_unpacker #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int LINE_BEATS     = 8,
    parameter int ADDR_WIDTH     = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_line_unpacker_if.slave fb
);
    localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;
    localparam int LINE_BYTES = LINE_BEATS * BEAT_BYTES;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int BEAT_LSB   = $clog2(BEAT_BYTES);
    localparam int BIDX_W     = OFF_W - BEAT_LSB;
    localparam int CNT_W      = $clog2(LINE_BEATS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(LINE_BEATS);

    typedef enum logic [1:0] {IDLE, REQ, FILL, FLUSH} state_e;

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0]          fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0]          drop_cnt_q, drop_cnt_d;
    logic [BUS_DATA_WIDTH-1:0] line_q [LINE_BEATS];

    logic [BIDX_W-1:0]         beat_idx;
    logic [BEAT_LSB-1:0]       byte_off;
    logic [BUS_DATA_WIDTH-1:0] cur_beat;
    logic [31:0]               cur_word;
    logic                      word_ready;
    logic                      last_word;
    logic                      capture;
    logic [CNT_W-1:0]          beat_inc;
    logic [CNT_W-1:0]          fill_rem;
    logic [ADDR_WIDTH-1:0]     redirect_pc;
    logic [ADDR_WIDTH-1:0]     next_pc;
    logic [ADDR_WIDTH-1:0]     line_addr;

    function automatic logic [31:0] select_word(input logic [BUS_DATA_WIDTH-1:0] beat,
                                                input logic [BEAT_LSB-1:0]       off);
        logic [BUS_DATA_WIDTH-1:0] sh;
        sh = beat >> {off, 3'b000};
        return sh[31:0];
    endfunction

    assign beat_idx    = pc_q[OFF_W-1:BEAT_LSB];
    assign byte_off    = pc_q[BEAT_LSB-1:0];
    assign cur_beat    = line_q[beat_idx];
    assign cur_word    = select_word(cur_beat, byte_off);
    assign word_ready  = CNT_W'(beat_idx) < fill_cnt_q;
    assign last_word   = &pc_q[OFF_W-1:2];
    assign capture     = (state_q == FILL) && fb.beat_valid && (fill_cnt_q < FULL);
    assign beat_inc    = CNT_W'(capture);
    // Beats still owed by the bus after abandoning the current fill, including one arriving now.
    assign fill_rem    = FULL - fill_cnt_q - beat_inc;
    assign redirect_pc = fb.start_pc & ~ADDR_WIDTH'(3);
    assign next_pc     = pc_q + ADDR_WIDTH'(4);
    assign line_addr   = {pc_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
    assign fb.busy     = (state_q != IDLE);

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        fill_cnt_d        = fill_cnt_q;
        drop_cnt_d        = drop_cnt_q;
        fb.line_req_valid = 1'b0;
        fb.line_req_addr  = '0;
        fb.inst_valid     = 1'b0;
        fb.inst           = '0;
        fb.inst_pc        = pc_q;

        unique case (state_q)
            IDLE: begin
                if (fb.start_valid) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end
            end

            REQ: begin
                fb.line_req_valid = 1'b1;
                fb.line_req_addr  = line_addr;
                if (fb.start_valid) begin
                    pc_d = redirect_pc;
                    // An accepted request still returns a whole line that must be drained.
                    if (fb.line_req_ack) begin
                        state_d    = FLUSH;
                        drop_cnt_d = FULL;
                    end
                end else if (fb.line_req_ack) begin
                    state_d    = FILL;
                    fill_cnt_d = '0;
                end
            end

            FILL: begin
                if (capture) begin
                    fill_cnt_d = fill_cnt_q + CNT_W'(1);
                end
                if (fb.start_valid) begin
                    pc_d = redirect_pc;
                    if (fill_rem == '0) begin
                        state_d = REQ;
                    end else begin
                        state_d    = FLUSH;
                        drop_cnt_d = fill_rem;
                    end
                end else begin
                    fb.inst_valid = word_ready;
                    fb.inst       = word_ready ? cur_word : '0;
                    if (word_ready && fb.inst_ready) begin
                        pc_d = next_pc;
                        if (last_word) begin
                            state_d = REQ;
                        end
                    end
                end
            end

            FLUSH: begin
                if (fb.start_valid) begin
                    pc_d = redirect_pc;
                end
                if (fb.beat_valid && (drop_cnt_q != '0)) begin
                    drop_cnt_d = drop_cnt_q - CNT_W'(1);
                end
                if (drop_cnt_d == '0) begin
                    state_d = REQ;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            fill_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fill_cnt_q <= fill_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Line buffer is pure data; validity is tracked by fill_cnt_q alone.
    always_ff @(posedge clk) begin
        if (capture) begin
            line_q[fill_cnt_q[BIDX_W-1:0]] <= fb.beat_data;
        end
    end
endmodule
